ssp_tx_serializer: RTL and testbench
====================================

Name: ssp_tx_serializer

Overview:
- Transmit back end of the SSP. Consumes words from the transmit FIFO (start_signal/read_cmd/TxData) and shifts them out serially, MSB first, in synchronous-serial frame format.
- Generates SSPCLKOUT from PCLK. That clock also drives the FIFO read side.
- Drives SSPTXD, SSPFSSOUT and SSPOE_B to the pads. Sits directly downstream of the transmit FIFO.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO data width.
- HALF_PERIOD, 1, SSPCLKOUT half-period in PCLK cycles (>=1); default gives SSPCLKOUT = PCLK/2.

Ports:
- PCLK  in  1  sole clock; every register is on posedge PCLK.
- CLEAR  in  1  synchronous, active-high reset.
- start_signal  in  1  FIFO non-empty.
- TxData  in  DATA_WIDTH  FIFO read data; valid after the SSPCLKOUT rise that sampled read_cmd=1.
- read_cmd  out  1  FIFO pop request; held exactly one SSPCLKOUT period.
- SSPCLKOUT  out  1  serial clock (registered divider output).
- SSPTXD  out  1  serial data.
- SSPFSSOUT  out  1  frame sync; one SSPCLKOUT period high, immediately before the MSB.
- SSPOE_B  out  1  active-low output enable; low only while data bits are driven.
- tx_busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and step:
  - Divider counts HALF_PERIOD PCLK cycles, then toggles SSPCLKOUT.
  - "step" = the PCLK edge at which SSPCLKOUT toggles 1->0.
  - All FSM state, outputs and read_cmd update only on steps. They are stable at the following SSPCLKOUT rise, where the FIFO and the external receiver sample.
- Reset (CLEAR=1 at a PCLK edge), effective the next cycle and regardless of state:
  - SSPCLKOUT=0, divider=0, state IDLE.
  - read_cmd=0, SSPTXD=0, SSPFSSOUT=0, SSPOE_B=1, tx_busy=0.
  - Shift register and bit count cleared.
  - A frame in progress is aborted and its word is discarded.
- FSM states: IDLE, FETCH, SYNC, SHIFT.
  - IDLE: at a step with start_signal=1, set read_cmd=1 and go to FETCH. Otherwise hold.
  - FETCH: the FIFO captures TxData at the mid-period rise. At the next step: read_cmd=0, SSPFSSOUT=1, latch TxData into hold register, go to SYNC.
  - SYNC: at the next step: SSPFSSOUT=0, load shift register from hold, SSPTXD=bit[DATA_WIDTH-1], SSPOE_B=0, count=DATA_WIDTH-1, go to SHIFT.
  - SHIFT: at each step, count decrements and SSPTXD presents the next lower bit.
- Continuous transfer inside SHIFT:
  - At the step that presents bit1 (count becomes 1): if start_signal=1, set read_cmd=1 for one period.
  - At the step that presents bit0: read_cmd=0. If a read was issued, latch TxData to hold and set SSPFSSOUT=1, concurrent with bit0.
  - At the step after bit0:
    - Read issued: go to SHIFT with the new MSB, exactly as from SYNC. This gives a zero-gap frame of DATA_WIDTH periods.
    - No read issued: go to IDLE with SSPOE_B=1, SSPTXD=0, SSPFSSOUT=0.
- Latency from IDLE: start_signal high at step N gives read_cmd at N, SSPFSSOUT at N+1, MSB at N+2, LSB at N+1+DATA_WIDTH.
- FIFO interaction:
  - read_cmd is never asserted when start_signal=0. This prevents popping an empty FIFO.
  - start_signal is sampled only at steps. Changes between steps are ignored.
- Width rules:
  - Bit count is clog2(DATA_WIDTH) bits; never wraps below 0.
  - Divider counter is clog2(HALF_PERIOD)+1 bits.

Decomposition:
- Shared package ssp_pkg: FSM state enum (IDLE, FETCH, SYNC, SHIFT), DEFAULT_DATA_WIDTH=8 (shared with the FIFO), DEFAULT_HALF_PERIOD=1.
- One sub-module, ssp_clk_gen: divider producing SSPCLKOUT and a one-PCLK step strobe, cleared by CLEAR.
- FSM, shift register and hold register live in ssp_tx_serializer.

Test Plan:
- Reset then idle: CLEAR for 3 PCLK, start_signal=0 for 40 PCLK -> SSPOE_B=1, SSPFSSOUT=0, SSPTXD=0, read_cmd=0. SSPCLKOUT toggles every PCLK.
- Single word 0xA5: start_signal=1 for one step, then 0 -> exactly one read_cmd period, one SSPFSSOUT period, then SSPTXD=1,0,1,0,0,1,0,1 at successive SSPCLKOUT rises with SSPOE_B=0. Afterwards IDLE, SSPOE_B=1.
- Back-to-back 0x3C then 0xC3: start_signal held high through the first frame -> second read_cmd during bit1 and SSPFSSOUT during bit0 of 0x3C. 16 consecutive data periods 00111100 11000011 with no SSPOE_B gap.
- Empty FIFO mid-stream: start_signal falls before bit1 of 0xFF -> no second read_cmd, no SSPFSSOUT at bit0, return to IDLE after 8 bits.
- Reset mid-frame: CLEAR at bit 4 of 0x5A -> next cycle SSPOE_B=1, SSPTXD=0, tx_busy=0. A new word 0x81 afterwards transmits correctly.
- HALF_PERIOD=2: word 0x96 -> SSPCLKOUT period is 4 PCLK. Same bit sequence and frame timing measured in SSPCLKOUT periods.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared SSP definitions: transmit FSM states and default geometry common
// to the serializer and the transmit FIFO.
package ssp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SYNC  = 2'd2,
    SHIFT = 2'd3
  } ssp_state_e;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_HALF_PERIOD = 1;

endpackage

// File: rtl/ssp_tx_serializer_if.sv
// FIFO read side and pad side of the SSP transmitter, grouped as one bundle.
// master = serializer, slave = FIFO plus pad/receiver side.
interface ssp_tx_serializer_if
  import ssp_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  start_signal;
  logic [DATA_WIDTH-1:0] TxData;
  logic                  read_cmd;
  logic                  SSPCLKOUT;
  logic                  SSPTXD;
  logic                  SSPFSSOUT;
  logic                  SSPOE_B;

  modport master (
    input  start_signal, TxData,
    output read_cmd, SSPCLKOUT, SSPTXD, SSPFSSOUT, SSPOE_B
  );

  modport slave (
    output start_signal, TxData,
    input  read_cmd, SSPCLKOUT, SSPTXD, SSPFSSOUT, SSPOE_B
  );
endinterface

// File: rtl/ssp_clk_gen.sv
// SSPCLKOUT divider: toggles every HALF_PERIOD PCLK cycles and flags the
// PCLK edge at which SSPCLKOUT falls (the serializer's step).
module ssp_clk_gen
  import ssp_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic PCLK,
  input  logic CLEAR,
  output logic sclk_o,
  output logic step_o
);
  localparam int               DIV_W    = $clog2(HALF_PERIOD) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             wrap_s;

  // Divider next state: wrap and toggle at the end of each half period.
  always_comb begin
    wrap_s = (div_q == DIV_LAST);
    div_d  = div_q;
    sclk_d = sclk_q;
    if (wrap_s) begin
      div_d  = {DIV_W{1'b0}};
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  // Divider registers with synchronous clear.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      div_q  <= {DIV_W{1'b0}};
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign step_o = wrap_s & sclk_q;
endmodule

// File: rtl/ssp_tx_serializer.sv
// SSP transmit back end: pops words from the TX FIFO and shifts them out MSB
// first with a one-period frame sync, chaining frames with no gap.
module ssp_tx_serializer
  import ssp_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic                PCLK,
  input  logic                CLEAR,
  ssp_tx_serializer_if.master bus,
  output logic                tx_busy
);
  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_BIT1 = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_BIT0 = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(0);

  ssp_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  read_q, read_d;
  logic                  txd_q, txd_d;
  logic                  fss_q, fss_d;
  logic                  oe_b_q, oe_b_d;
  logic                  issued_q, issued_d;
  logic                  busy_q, busy_d;
  logic                  step_s, sclk_s, load_s;

  ssp_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
    .PCLK   (PCLK),
    .CLEAR  (CLEAR),
    .sclk_o (sclk_s),
    .step_o (step_s)
  );

  // FSM next state; everything advances only on a step.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    hold_d   = hold_q;
    read_d   = read_q;
    txd_d    = txd_q;
    fss_d    = fss_q;
    oe_b_d   = oe_b_q;
    issued_d = issued_q;
    load_s   = 1'b0;
    if (step_s) begin
      case (state_q)
        IDLE: begin
          if (bus.start_signal) begin
            read_d  = 1'b1;
            state_d = FETCH;
          end else begin
            read_d  = 1'b0;
          end
        end
        FETCH: begin
          read_d  = 1'b0;
          fss_d   = 1'b1;
          hold_d  = bus.TxData;
          state_d = SYNC;
        end
        SYNC: load_s = 1'b1;
        SHIFT: begin
          if (bitcnt_q == CNT_END) begin
            if (issued_q) begin
              load_s = 1'b1;
            end else begin
              state_d = IDLE;
              oe_b_d  = 1'b1;
              txd_d   = 1'b0;
              fss_d   = 1'b0;
            end
          end else begin
            bitcnt_d = bitcnt_q - CNT_W'(1);
            shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
            txd_d    = shift_q[DATA_WIDTH-2];
            // Prefetch the next word while bit1 is on the line.
            if ((bitcnt_q == CNT_BIT1) && bus.start_signal) begin
              read_d   = 1'b1;
              issued_d = 1'b1;
            end else if (bitcnt_q == CNT_BIT0) begin
              read_d = 1'b0;
              if (issued_q) begin
                hold_d = bus.TxData;
                fss_d  = 1'b1;
              end else begin
                fss_d  = 1'b0;
              end
            end else begin
              read_d = read_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      load_s = 1'b0;
    end
    if (load_s) begin
      state_d  = SHIFT;
      shift_d  = hold_q;
      txd_d    = hold_q[DATA_WIDTH-1];
      oe_b_d   = 1'b0;
      fss_d    = 1'b0;
      bitcnt_d = CNT_TOP;
      issued_d = 1'b0;
    end else begin
      issued_d = issued_d;
    end
    busy_d = (state_d != IDLE);
  end

  // FSM, datapath and output registers with synchronous clear.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q  <= IDLE;
      bitcnt_q <= {CNT_W{1'b0}};
      shift_q  <= {DATA_WIDTH{1'b0}};
      hold_q   <= {DATA_WIDTH{1'b0}};
      read_q   <= 1'b0;
      txd_q    <= 1'b0;
      fss_q    <= 1'b0;
      oe_b_q   <= 1'b1;
      issued_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      read_q   <= read_d;
      txd_q    <= txd_d;
      fss_q    <= fss_d;
      oe_b_q   <= oe_b_d;
      issued_q <= issued_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.read_cmd  = read_q;
  assign bus.SSPCLKOUT = sclk_s;
  assign bus.SSPTXD    = txd_q;
  assign bus.SSPFSSOUT = fss_q;
  assign bus.SSPOE_B   = oe_b_q;
  assign tx_busy       = busy_q;
endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Directed bench for ssp_tx_serializer: FIFO model, per-SSPCLKOUT-rise trace
// capture and a bit scoreboard, with frames checked against expected timing.
module tb_ssp_tx_serializer;
  import ssp_pkg::*;

  typedef struct packed {
    logic rd;
    logic fss;
    logic oe_b;
    logic txd;
  } tr_t;

  logic PCLK = 1'b0;
  logic CLEAR;
  logic busy1, busy2;

  always #5 PCLK = ~PCLK;

  ssp_tx_serializer_if #(.DATA_WIDTH(8)) bus1 ();
  ssp_tx_serializer_if #(.DATA_WIDTH(8)) bus2 ();

  ssp_tx_serializer #(.DATA_WIDTH(8), .HALF_PERIOD(1)) dut1 (
    .PCLK(PCLK), .CLEAR(CLEAR), .bus(bus1.master), .tx_busy(busy1));
  ssp_tx_serializer #(.DATA_WIDTH(8), .HALF_PERIOD(2)) dut2 (
    .PCLK(PCLK), .CLEAR(CLEAR), .bus(bus2.master), .tx_busy(busy2));

  tr_t        tr1[$];
  tr_t        tr2[$];
  logic [7:0] fifo[$];
  logic       exp_bits[$];
  int         passed = 0;
  int         total = 0;
  int         underflow = 0;

  task automatic chk(string tag, int idx, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, idx, obs, exp);
  endtask

  task automatic push_word(logic [7:0] w);
    fifo.push_back(w);
    for (int b = 7; b >= 0; b--) exp_bits.push_back(w[b]);
  endtask

  // FIFO model for dut1: pops on the SSPCLKOUT rise that sees read_cmd.
  always @(posedge bus1.SSPCLKOUT) begin
    if (bus1.read_cmd === 1'b1) begin
      if (fifo.size() != 0) bus1.TxData = fifo.pop_front();
      else underflow++;
    end
  end

  always @(negedge PCLK) bus1.start_signal = (fifo.size() != 0);

  // Receiver side: record every SSPCLKOUT rise and score data bits.
  always @(posedge bus1.SSPCLKOUT) begin
    #1;
    tr1.push_back(tr_t'{bus1.read_cmd, bus1.SSPFSSOUT, bus1.SSPOE_B, bus1.SSPTXD});
    if (bus1.SSPOE_B === 1'b0) begin
      if (exp_bits.size() != 0) chk("txd_sb", tr1.size(), 32'(bus1.SSPTXD), 32'(exp_bits.pop_front()));
      else chk("sb_empty", tr1.size(), exp_bits.size(), 1);
    end
  end

  always @(posedge bus2.SSPCLKOUT) begin
    #1;
    tr2.push_back(tr_t'{bus2.read_cmd, bus2.SSPFSSOUT, bus2.SSPOE_B, bus2.SSPTXD});
  end

  // Frame timing in SSPCLKOUT periods, aligned on the first read_cmd rise.
  task automatic check_burst(string tag, input tr_t tr[$], input logic [7:0] words[$]);
    int  i0 = -1;
    int  n = words.size();
    int  len = 3 + 8 * n;
    int  bad = 0;
    int  k, b;
    tr_t e;
    tr_t idle_t = tr_t'{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < tr.size(); i++) if (tr[i].rd === 1'b1 && i0 < 0) i0 = i;
    chk({tag, "_frame_seen"}, i0, 32'((i0 >= 0) && (tr.size() >= i0 + len)), 1);
    if ((i0 < 0) || (tr.size() < i0 + len)) return;
    for (int i = 0; i < i0; i++) if (tr[i] !== idle_t) bad++;
    for (int i = i0 + len; i < tr.size(); i++) if (tr[i] !== idle_t) bad++;
    chk({tag, "_idle_around"}, i0, bad, 0);
    for (int p = 0; p < len; p++) begin
      e = idle_t;
      if (p == 0) e.rd = 1'b1;
      if (p == 1) e.fss = 1'b1;
      if (p >= 2 && p < 2 + 8 * n) begin
        k = (p - 2) / 8;
        b = (p - 2) % 8;
        e.oe_b = 1'b0;
        e.txd  = words[k][7-b];
        if (k < n - 1 && b == 6) e.rd = 1'b1;
        if (k < n - 1 && b == 7) e.fss = 1'b1;
      end
      chk({tag, "_period"}, p, 32'(tr[i0+p]), 32'(e));
    end
  endtask

  initial begin
    logic [7:0] w[$];
    logic       prev;
    int         bad_oe, bad_fss, bad_txd, bad_rd, bad_tog, seen, rises[$];

    CLEAR = 1'b1;
    bus2.start_signal = 1'b0;
    bus2.TxData = 8'h00;
    repeat (3) @(negedge PCLK);
    chk("rst_sclk", 0, 32'(bus1.SSPCLKOUT), 0);
    chk("rst_read", 0, 32'(bus1.read_cmd), 0);
    chk("rst_txd", 0, 32'(bus1.SSPTXD), 0);
    chk("rst_fss", 0, 32'(bus1.SSPFSSOUT), 0);
    chk("rst_oe_b", 0, 32'(bus1.SSPOE_B), 1);
    chk("rst_busy", 0, 32'(busy1), 0);
    CLEAR = 1'b0;

    bad_oe = 0; bad_fss = 0; bad_txd = 0; bad_rd = 0; bad_tog = 0;
    prev = bus1.SSPCLKOUT;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      if (bus1.SSPOE_B !== 1'b1) bad_oe++;
      if (bus1.SSPFSSOUT !== 1'b0) bad_fss++;
      if (bus1.SSPTXD !== 1'b0) bad_txd++;
      if (bus1.read_cmd !== 1'b0) bad_rd++;
      if (bus1.SSPCLKOUT === prev) bad_tog++;
      prev = bus1.SSPCLKOUT;
    end
    chk("idle_oe_b", 0, bad_oe, 0);
    chk("idle_fss", 0, bad_fss, 0);
    chk("idle_txd", 0, bad_txd, 0);
    chk("idle_read", 0, bad_rd, 0);
    chk("idle_sclk_toggle", 0, bad_tog, 0);

    tr1.delete();
    push_word(8'hA5);
    repeat (40) @(negedge PCLK);
    w = {8'hA5};
    check_burst("single_a5", tr1, w);
    chk("a5_busy_after", 0, 32'(busy1), 0);

    tr1.delete();
    push_word(8'h3C);
    push_word(8'hC3);
    repeat (60) @(negedge PCLK);
    w = {8'h3C, 8'hC3};
    check_burst("b2b_3c_c3", tr1, w);

    tr1.delete();
    push_word(8'hFF);
    repeat (40) @(negedge PCLK);
    w = {8'hFF};
    check_burst("empty_ff", tr1, w);

    tr1.delete();
    push_word(8'h5A);
    seen = 0;
    for (int c = 0; c < 80 && seen < 4; c++) begin
      @(negedge PCLK);
      seen = 0;
      foreach (tr1[i]) if (tr1[i].oe_b === 1'b0) seen++;
    end
    chk("abort_reached_bit4", 0, seen, 4);
    CLEAR = 1'b1;
    exp_bits.delete();
    @(negedge PCLK);
    CLEAR = 1'b0;
    chk("abort_oe_b", 0, 32'(bus1.SSPOE_B), 1);
    chk("abort_txd", 0, 32'(bus1.SSPTXD), 0);
    chk("abort_busy", 0, 32'(busy1), 0);
    chk("abort_read", 0, 32'(bus1.read_cmd), 0);
    chk("abort_sclk", 0, 32'(bus1.SSPCLKOUT), 0);
    tr1.delete();
    push_word(8'h81);
    repeat (40) @(negedge PCLK);
    w = {8'h81};
    check_burst("after_abort_81", tr1, w);
    chk("sb_drained", 0, exp_bits.size(), 0);
    chk("fifo_underflow", 0, underflow, 0);

    tr2.delete();
    @(negedge PCLK);
    bus2.TxData = 8'h96;
    bus2.start_signal = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge PCLK);
      if (bus2.read_cmd === 1'b1) seen = 1;
    end
    chk("hp2_read_seen", 0, seen, 1);
    bus2.start_signal = 1'b0;
    prev = bus2.SSPCLKOUT;
    for (int c = 0; c < 24; c++) begin
      @(negedge PCLK);
      if (prev === 1'b0 && bus2.SSPCLKOUT === 1'b1) rises.push_back(c);
      prev = bus2.SSPCLKOUT;
    end
    chk("hp2_rises", 0, 32'(rises.size() >= 2), 1);
    if (rises.size() >= 2) chk("hp2_period_pclk", 0, rises[1] - rises[0], 4);
    repeat (80) @(negedge PCLK);
    w = {8'h96};
    check_burst("hp2_96", tr2, w);
    chk("hp2_busy_after", 0, 32'(busy2), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
